// File: rtl/oc8051_mul_seq.sv
// oc8051_mul_seq: sequences a MUL AB through the 2-bit-per-cycle multiplier,
// holding its operands, pacing its enable, and writing back product and flags.
module oc8051_mul_seq #(
  parameter int MUL_CYCLES    = 4,
  parameter bit START_IN_DONE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       flush,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       mul_enable,
  output logic [7:0] mul_src1,
  output logic [7:0] mul_src2,
  input  logic [7:0] mul_des1,
  input  logic [7:0] mul_des2,
  input  logic       mul_ov,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_acc,
  output logic [7:0] res_b,
  output logic       ov_flag,
  output logic       cy_flag
);

  localparam int             CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_enable_q, mul_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       src1_q, src1_d;
  logic [7:0]       src2_q, src2_d;
  logic [7:0]       res_acc_q, res_acc_d;
  logic [7:0]       res_b_q, res_b_d;
  logic             ov_q, ov_d;
  logic             cy_q, cy_d;
  logic             accept;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_enable_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    src1_d       = src1_q;
    src2_d       = src2_q;
    res_acc_d    = res_acc_q;
    res_b_d      = res_b_q;
    ov_d         = ov_q;
    cy_d         = cy_q;
    accept       = 1'b0;

    unique case (state_q)
      S_IDLE: accept = start && !flush;

      S_RUN: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          // Final slice: the multiplier's combinational output is the full product.
          if (!flush) begin
            res_acc_d = mul_des2;
            res_b_d   = mul_des1;
            ov_d      = mul_ov;
            cy_d      = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          mul_enable_d = 1'b1;
          busy_d       = 1'b1;
          if (flush) state_d = S_DRAIN;
        end
      end

      // Keep the multiplier's own counter running until it wraps, then drop out.
      S_DRAIN: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          mul_enable_d = 1'b1;
          busy_d       = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        accept  = START_IN_DONE && start && !flush;
      end

      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      src1_d       = op_a;
      src2_d       = op_b;
      cnt_d        = '0;
      state_d      = S_RUN;
      mul_enable_d = 1'b1;
      busy_d       = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mul_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      // NOTE: operand and result holding registers are reset too, so write-back values are defined after reset.
      src1_q       <= '0;
      src2_q       <= '0;
      res_acc_q    <= '0;
      res_b_q      <= '0;
      ov_q         <= 1'b0;
      cy_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_enable_q <= mul_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      res_acc_q    <= res_acc_d;
      res_b_q      <= res_b_d;
      ov_q         <= ov_d;
      cy_q         <= cy_d;
    end
  end

  assign mul_enable = mul_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;
  assign res_acc    = res_acc_q;
  assign res_b      = res_b_q;
  assign ov_flag    = ov_q;
  assign cy_flag    = cy_q;

  // Enable and stall must track each other; operands never move mid-operation.
  a_en_is_busy : assert property (@(posedge clk) disable iff (rst) mul_enable_q == busy_q);
  a_done_not_busy : assert property (@(posedge clk) disable iff (rst) !(done_q && busy_q));
  a_src_stable : assert property (@(posedge clk) disable iff (rst)
    busy_q |=> ($stable(src1_q) && $stable(src2_q)));

endmodule

// File: tb/tb_oc8051_mul_seq.sv
// Bench for oc8051_mul_seq: two instances (back-to-back on / off) share stimulus;
// each drives a behavioural 2-bit-slice multiplier stub and is checked against a product model.
module tb_oc8051_mul_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;

  // Index 0: START_IN_DONE=1, index 1: START_IN_DONE=0.
  logic       mul_enable [2];
  logic       busy       [2];
  logic       done       [2];
  logic       ov_flag    [2];
  logic       cy_flag    [2];
  logic       mul_ov     [2];
  logic [7:0] mul_src1   [2];
  logic [7:0] mul_src2   [2];
  logic [7:0] mul_des1   [2];
  logic [7:0] mul_des2   [2];
  logic [7:0] res_acc    [2];
  logic [7:0] res_b      [2];
  logic [1:0] mcnt       [2];
  logic [15:0] stub_p    [2];

  int tests = 0;
  int fails = 0;

  // Observations gathered by drive_op.
  int          en_cnt  [2];
  int          n_done  [2];
  int          done_k1 [2];
  int          done_k2 [2];
  int          bad_cyc [2];
  logic [15:0] r1      [2];
  logic [15:0] r2      [2];
  logic        ov1     [2];
  logic        ov2     [2];
  logic        cy1     [2];

  // Model of the last written-back result (same for both instances unless noted).
  logic [15:0] m_res = 16'h0000;
  logic        m_ov  = 1'b0;

  localparam logic [7:0]  DA  [3] = '{8'h50, 8'h0F, 8'hFF};
  localparam logic [7:0]  DB  [3] = '{8'hA0, 8'h0F, 8'hFF};
  localparam logic [15:0] DP  [3] = '{16'h3200, 16'h00E1, 16'hFE01};
  localparam logic        DOV [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  oc8051_mul_seq #(.MUL_CYCLES(4), .START_IN_DONE(1'b1)) dut_b2b (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op_a(op_a), .op_b(op_b),
    .mul_enable(mul_enable[0]), .mul_src1(mul_src1[0]), .mul_src2(mul_src2[0]),
    .mul_des1(mul_des1[0]), .mul_des2(mul_des2[0]), .mul_ov(mul_ov[0]),
    .busy(busy[0]), .done(done[0]), .res_acc(res_acc[0]), .res_b(res_b[0]),
    .ov_flag(ov_flag[0]), .cy_flag(cy_flag[0])
  );

  oc8051_mul_seq #(.MUL_CYCLES(4), .START_IN_DONE(1'b0)) dut_nob2b (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op_a(op_a), .op_b(op_b),
    .mul_enable(mul_enable[1]), .mul_src1(mul_src1[1]), .mul_src2(mul_src2[1]),
    .mul_des1(mul_des1[1]), .mul_des2(mul_des2[1]), .mul_ov(mul_ov[1]),
    .busy(busy[1]), .done(done[1]), .res_acc(res_acc[1]), .res_b(res_b[1]),
    .ov_flag(ov_flag[1]), .cy_flag(cy_flag[1])
  );

  // Multiplier stub: a free-running 2-bit slice counter; only on its last slice
  // is the combinational output the true product, otherwise it is corrupted.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) mcnt[i] <= 2'd0;
      else if (mul_enable[i]) mcnt[i] <= mcnt[i] + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stub_p[i] = 16'(mul_src1[i]) * 16'(mul_src2[i]);
      if (mcnt[i] != 2'd3) stub_p[i] = stub_p[i] ^ 16'h5AC3;
      mul_des1[i] = stub_p[i][15:8];
      mul_des2[i] = stub_p[i][7:0];
      mul_ov[i]   = |stub_p[i][15:8];
    end
  end

  // Issue one start (a,b) and watch 12 cycles. flush_k: cycle during which flush
  // is held (0 = together with start, -1 = none). s2_k: cycle of a second start.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input int flush_k,
                          input int s2_k, input logic [7:0] a2, input logic [7:0] b2);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    flush = (flush_k == 0);
    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; n_done[i] = 0; done_k1[i] = -1; done_k2[i] = -1; bad_cyc[i] = 0;
      r1[i] = 16'hxxxx; r2[i] = 16'hxxxx; ov1[i] = 1'bx; ov2[i] = 1'bx; cy1[i] = 1'bx;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      if (k == s2_k) begin
        start = 1'b1;
        op_a  = a2;
        op_b  = b2;
      end
      if (k == flush_k) flush = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (mul_enable[i] === 1'b1) en_cnt[i]++;
        if (mul_enable[i] !== busy[i] || (done[i] === 1'b1 && busy[i] === 1'b1)) bad_cyc[i]++;
        if (done[i] === 1'b1) begin
          n_done[i]++;
          if (n_done[i] == 1) begin
            done_k1[i] = k; r1[i] = {res_b[i], res_acc[i]}; ov1[i] = ov_flag[i]; cy1[i] = cy_flag[i];
          end else begin
            done_k2[i] = k; r2[i] = {res_b[i], res_acc[i]}; ov2[i] = ov_flag[i];
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({mul_enable[i], busy[i], done[i], ov_flag[i], cy_flag[i]} !== 5'b0) begin
        fails++;
        $display("FAIL reset_ctrl dut%0d: got %b expected 00000", i,
                 {mul_enable[i], busy[i], done[i], ov_flag[i], cy_flag[i]});
      end
      tests++;
      if ({mul_src1[i], mul_src2[i], res_b[i], res_acc[i]} !== 32'h0) begin
        fails++;
        $display("FAIL reset_data dut%0d: got %h expected 00000000", i,
                 {mul_src1[i], mul_src2[i], res_b[i], res_acc[i]});
      end
    end
    rst = 1'b0;
    m_res = 16'h0000;
    m_ov  = 1'b0;
  endtask

  task automatic test_directed();
    for (int t = 0; t < 3; t++) begin
      drive_op(DA[t], DB[t], -1, -1, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if ({8'(n_done[i]), 8'(done_k1[i]), 8'(en_cnt[i]), 8'(bad_cyc[i])} !== 32'h01050400) begin
          fails++;
          $display("FAIL directed%0d_timing dut%0d: ndone=%0d done_at=%0d en=%0d bad=%0d expected 1/5/4/0",
                   t, i, n_done[i], done_k1[i], en_cnt[i], bad_cyc[i]);
        end
        tests++;
        if ({r1[i], ov1[i], cy1[i]} !== {DP[t], DOV[t], 1'b0}) begin
          fails++;
          $display("FAIL directed%0d_result dut%0d: got %h ov=%b cy=%b expected %h ov=%b cy=0",
                   t, i, r1[i], ov1[i], cy1[i], DP[t], DOV[t]);
        end
      end
    end
    m_res = DP[2];
    m_ov  = DOV[2];
  endtask

  task automatic test_back_to_back();
    drive_op(8'h12, 8'h34, -1, 5, 8'h03, 8'h07);
    tests++;
    if ({8'(n_done[0]), 8'(done_k1[0]), 8'(done_k2[0]), 8'(en_cnt[0])} !== 32'h02050A08) begin
      fails++;
      $display("FAIL b2b_timing dut0: ndone=%0d at=%0d,%0d en=%0d expected 2 at 5,10 en=8",
               n_done[0], done_k1[0], done_k2[0], en_cnt[0]);
    end
    tests++;
    if ({r1[0], ov1[0], r2[0], ov2[0]} !== {16'h03A8, 1'b1, 16'h0015, 1'b0}) begin
      fails++;
      $display("FAIL b2b_result dut0: got %h/%b then %h/%b expected 03a8/1 then 0015/0",
               r1[0], ov1[0], r2[0], ov2[0]);
    end
    tests++;
    if ({8'(n_done[1]), 8'(done_k1[1]), 8'(en_cnt[1]), r1[1]} !== {8'd1, 8'd5, 8'd4, 16'h03A8}) begin
      fails++;
      $display("FAIL nob2b dut1: ndone=%0d at=%0d en=%0d res=%h expected 1 at 5 en=4 res=03a8",
               n_done[1], done_k1[1], en_cnt[1], r1[1]);
    end
    tests++;
    if ({mul_src1[1], mul_src2[1], res_b[1], res_acc[1]} !== 32'h123403A8) begin
      fails++;
      $display("FAIL nob2b_hold dut1: got %h expected 123403a8",
               {mul_src1[1], mul_src2[1], res_b[1], res_acc[1]});
    end
  endtask

  task automatic test_flush();
    drive_op(8'h0F, 8'h0F, -1, -1, 8'h00, 8'h00);
    // Flush while cnt==1: drain to a full wrap, nothing written back.
    drive_op(8'h80, 8'h02, 2, -1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(n_done[i]), 8'(en_cnt[i]), 8'(bad_cyc[i]), res_b[i], res_acc[i], ov_flag[i]}
          !== {8'd0, 8'd4, 8'd0, 16'h00E1, 1'b0}) begin
        fails++;
        $display("FAIL flush_cnt1 dut%0d: ndone=%0d en=%0d bad=%0d res=%h ov=%b expected 0/4/0 res=00e1 ov=0",
                 i, n_done[i], en_cnt[i], bad_cyc[i], {res_b[i], res_acc[i]}, ov_flag[i]);
      end
    end
    drive_op(8'h10, 8'h10, -1, -1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(done_k1[i]), r1[i], ov1[i]} !== {8'd5, 16'h0100, 1'b1}) begin
        fails++;
        $display("FAIL after_flush dut%0d: at=%0d res=%h ov=%b expected at=5 res=0100 ov=1",
                 i, done_k1[i], r1[i], ov1[i]);
      end
    end
    // Flush on the last slice: straight to idle, no capture.
    drive_op(8'h33, 8'h44, 4, -1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(n_done[i]), 8'(en_cnt[i]), res_b[i], res_acc[i]} !== {8'd0, 8'd4, 16'h0100}) begin
        fails++;
        $display("FAIL flush_cnt3 dut%0d: ndone=%0d en=%0d res=%h expected 0/4 res=0100",
                 i, n_done[i], en_cnt[i], {res_b[i], res_acc[i]});
      end
    end
    // Start and flush together in idle: start is dropped, operands untouched.
    drive_op(8'h5A, 8'h6B, 0, -1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(n_done[i]), 8'(en_cnt[i]), mul_src1[i], mul_src2[i]} !== {8'd0, 8'd0, 8'h33, 8'h44}) begin
        fails++;
        $display("FAIL flush_idle dut%0d: ndone=%0d en=%0d src=%h%h expected 0/0 src=3344",
                 i, n_done[i], en_cnt[i], mul_src1[i], mul_src2[i]);
      end
    end
    // Flush in the done cycle: done still pulses, results stand.
    drive_op(8'h07, 8'h09, 5, -1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(n_done[i]), 8'(done_k1[i]), res_b[i], res_acc[i], ov_flag[i]}
          !== {8'd1, 8'd5, 16'h003F, 1'b0}) begin
        fails++;
        $display("FAIL flush_done dut%0d: ndone=%0d at=%0d res=%h ov=%b expected 1 at 5 res=003f ov=0",
                 i, n_done[i], done_k1[i], {res_b[i], res_acc[i]}, ov_flag[i]);
      end
    end
    m_res = 16'h003F;
    m_ov  = 1'b0;
  endtask

  task automatic test_start_in_run();
    drive_op(8'h21, 8'h43, -1, 2, 8'h99, 8'h77);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(n_done[i]), 8'(done_k1[i]), 8'(en_cnt[i]), r1[i], mul_src1[i], mul_src2[i]}
          !== {8'd1, 8'd5, 8'd4, 16'h08A3, 8'h21, 8'h43}) begin
        fails++;
        $display("FAIL start_in_run dut%0d: ndone=%0d at=%0d en=%0d res=%h src=%h%h expected 1/5/4 res=08a3 src=2143",
                 i, n_done[i], done_k1[i], en_cnt[i], r1[i], mul_src1[i], mul_src2[i]);
      end
    end
    m_res = 16'h08A3;
    m_ov  = 1'b1;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    op_a  = 8'h55;
    op_b  = 8'h66;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({mul_enable[i], busy[i], done[i], ov_flag[i], cy_flag[i], mul_src1[i], mul_src2[i],
           res_b[i], res_acc[i]} !== 37'h0) begin
        fails++;
        $display("FAIL reset_mid dut%0d: en=%b busy=%b done=%b ov=%b src=%h%h res=%h expected all 0",
                 i, mul_enable[i], busy[i], done[i], ov_flag[i], mul_src1[i], mul_src2[i],
                 {res_b[i], res_acc[i]});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_op(8'hC8, 8'h05, -1, -1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({8'(done_k1[i]), 8'(en_cnt[i]), r1[i], ov1[i]} !== {8'd5, 8'd4, 16'h03E8, 1'b1}) begin
        fails++;
        $display("FAIL after_reset dut%0d: at=%0d en=%0d res=%h ov=%b expected at=5 en=4 res=03e8 ov=1",
                 i, done_k1[i], en_cnt[i], r1[i], ov1[i]);
      end
    end
    m_res = 16'h03E8;
    m_ov  = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, b, a2, b2;
      int mode, fk, sk, exp_en;
      logic accepted, captured;
      a    = 8'($urandom);
      b    = 8'($urandom);
      a2   = 8'($urandom);
      b2   = 8'($urandom);
      mode = int'($urandom_range(0, 9));
      fk   = -1;
      sk   = -1;
      if (mode == 6) fk = 0;
      else if (mode == 7) fk = int'($urandom_range(1, 4));
      else if (mode == 8) fk = 5;
      else if (mode == 9) sk = int'($urandom_range(1, 4));
      accepted = (fk != 0);
      captured = accepted && !(fk >= 1 && fk <= 4);
      exp_en   = accepted ? 4 : 0;
      if (captured) begin
        m_res = 16'(a) * 16'(b);
        m_ov  = (m_res > 16'd255);
      end
      drive_op(a, b, fk, sk, a2, b2);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (n_done[i] != int'(captured) || (captured && done_k1[i] != 5) ||
            en_cnt[i] != exp_en || bad_cyc[i] != 0) begin
          fails++;
          $display("FAIL rand%0d_timing dut%0d: ndone=%0d at=%0d en=%0d bad=%0d expected ndone=%0d at=5 en=%0d",
                   n, i, n_done[i], done_k1[i], en_cnt[i], bad_cyc[i], captured, exp_en);
        end
        tests++;
        if ({res_b[i], res_acc[i], ov_flag[i], cy_flag[i]} !== {m_res, m_ov, 1'b0}) begin
          fails++;
          $display("FAIL rand%0d_result dut%0d (%h*%h mode %0d): got %h ov=%b cy=%b expected %h ov=%b cy=0",
                   n, i, a, b, mode, {res_b[i], res_acc[i]}, ov_flag[i], cy_flag[i], m_res, m_ov);
        end
        if (accepted) begin
          tests++;
          if ({mul_src1[i], mul_src2[i]} !== {a, b}) begin
            fails++;
            $display("FAIL rand%0d_src dut%0d: got %h%h expected %h%h",
                     n, i, mul_src1[i], mul_src2[i], a, b);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_start_in_run();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

endmodule
